// File: rtl/pawn_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : pawn_sweep
//  Purpose  : Sweeps a 64-square board held in SDRAM. Every square holding a
//             pawn of the selected side is handed to a pawn move generator.
//             The number of moves the generator reports is summed, and the
//             destination pointer advances by one board image per move.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             slave_*               - CPU register slave
//                                     (0 start/busy, 1 src, 2 dest, 3 side,
//                                      4 total_moves)
//             bm_*                  - board read master (SDRAM)
//             gm_*                  - pawn generator master
//  Revision : 1.0  initial release
// ============================================================================
module pawn_sweep #(
  parameter logic signed [7:0] PAWN_CODE = 8'sd1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        bm_waitrequest,
  output logic [31:0] bm_address,
  output logic        bm_read,
  input  logic [31:0] bm_readdata,
  input  logic        bm_readdatavalid,
  input  logic        gm_waitrequest,
  output logic [3:0]  gm_address,
  output logic        gm_read,
  input  logic [31:0] gm_readdata,
  output logic        gm_write,
  output logic [31:0] gm_writedata
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_SQ  = 4'd1,
    S_WT_SQ  = 4'd2,
    S_CHECK  = 4'd3,
    S_G_SRC  = 4'd4,
    S_G_DST  = 4'd5,
    S_G_X    = 4'd6,
    S_G_Y    = 4'd7,
    S_G_GO   = 4'd8,
    S_G_POLL = 4'd9,
    S_ACCUM  = 4'd10,
    S_NEXT   = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic [31:0] r_src_board_addr;
  logic [31:0] r_dest_base_addr;
  logic        r_side;
  logic [5:0]  r_sq;
  logic [31:0] r_dest_ptr;
  logic [31:0] r_total_moves;
  logic [7:0]  r_sq_pc;
  logic [31:0] r_cnt;

  logic        w_busy;
  logic        w_start;
  logic [7:0]  w_target;

  // Only the low byte of a board word carries the piece code; slave_read is
  // not needed because read data is purely combinational.
  logic        w_unused_ok;
  assign w_unused_ok = &{1'b0, bm_readdata[31:8], slave_read};

  assign w_busy   = (r_state != S_IDLE);
  assign w_start  = slave_write && (slave_address == 4'd0) && !w_busy;
  assign w_target = r_side ? -PAWN_CODE : PAWN_CODE;

  assign slave_waitrequest = 1'b0;

  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0:    slave_readdata = {31'd0, w_busy};
      4'd4:    slave_readdata = r_total_moves;
      default: slave_readdata = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and bus strobes; strobes decode from state only, so an
  // asynchronous reset drops them immediately.
  always_comb begin
    w_state_nx   = r_state;
    bm_read      = 1'b0;
    bm_address   = 32'd0;
    gm_read      = 1'b0;
    gm_write     = 1'b0;
    gm_address   = 4'd0;
    gm_writedata = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nx = S_RD_SQ;
      end
      S_RD_SQ: begin
        bm_read    = 1'b1;
        bm_address = r_src_board_addr + {24'd0, r_sq, 2'b00};
        if (!bm_waitrequest) w_state_nx = S_WT_SQ;
      end
      S_WT_SQ: begin
        if (bm_readdatavalid) w_state_nx = S_CHECK;
      end
      S_CHECK: begin
        w_state_nx = (r_sq_pc == w_target) ? S_G_SRC : S_NEXT;
      end
      S_G_SRC: begin
        gm_write     = 1'b1;
        gm_address   = 4'd1;
        gm_writedata = r_src_board_addr;
        if (!gm_waitrequest) w_state_nx = S_G_DST;
      end
      S_G_DST: begin
        gm_write     = 1'b1;
        gm_address   = 4'd2;
        gm_writedata = r_dest_ptr;
        if (!gm_waitrequest) w_state_nx = S_G_X;
      end
      S_G_X: begin
        gm_write     = 1'b1;
        gm_address   = 4'd3;
        gm_writedata = {29'd0, r_sq[2:0]};
        if (!gm_waitrequest) w_state_nx = S_G_Y;
      end
      S_G_Y: begin
        gm_write     = 1'b1;
        gm_address   = 4'd4;
        gm_writedata = {29'd0, r_sq[5:3]};
        if (!gm_waitrequest) w_state_nx = S_G_GO;
      end
      S_G_GO: begin
        gm_write     = 1'b1;
        gm_address   = 4'd0;
        gm_writedata = 32'd0;
        if (!gm_waitrequest) w_state_nx = S_G_POLL;
      end
      S_G_POLL: begin
        gm_read    = 1'b1;
        gm_address = 4'd0;
        if (!gm_waitrequest) w_state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        w_state_nx = S_NEXT;
      end
      S_NEXT: begin
        w_state_nx = (r_sq == 6'd63) ? S_IDLE : S_RD_SQ;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_board_addr <= 32'd0;
      r_dest_base_addr <= 32'd0;
      r_side           <= 1'b0;
      r_sq             <= 6'd0;
      r_dest_ptr       <= 32'd0;
      r_total_moves    <= 32'd0;
      r_sq_pc          <= 8'd0;
      r_cnt            <= 32'd0;
    end else begin
      // Configuration is frozen for the duration of a sweep.
      if (slave_write && !w_busy) begin
        case (slave_address)
          4'd1:    r_src_board_addr <= slave_writedata;
          4'd2:    r_dest_base_addr <= slave_writedata;
          4'd3:    r_side           <= slave_writedata[0];
          default: ;
        endcase
      end
      if (w_start) begin
        r_sq          <= 6'd0;
        r_dest_ptr    <= r_dest_base_addr;
        r_total_moves <= 32'd0;
      end
      if ((r_state == S_WT_SQ) && bm_readdatavalid) begin
        r_sq_pc <= bm_readdata[7:0];
      end
      if ((r_state == S_G_POLL) && !gm_waitrequest) begin
        r_cnt <= gm_readdata;
      end
      if (r_state == S_ACCUM) begin
        r_total_moves <= r_total_moves + r_cnt;
        // Each generated move occupies one 64-square x 4-byte board image.
        r_dest_ptr    <= r_dest_ptr + {r_cnt[23:0], 8'd0};
      end
      if ((r_state == S_NEXT) && (r_sq != 6'd63)) begin
        r_sq <= r_sq + 6'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pawn_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pawn_sweep
//  Purpose  : Self-checking bench for pawn_sweep with SDRAM and generator
//             bus models and a square-by-square reference of the sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pawn_sweep;

  localparam logic signed [7:0] PAWN = 8'sd1;

  logic        clk;
  logic        rst_n;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        bm_waitrequest;
  logic [31:0] bm_address;
  logic        bm_read;
  logic [31:0] bm_readdata;
  logic        bm_readdatavalid;
  logic        gm_waitrequest;
  logic [3:0]  gm_address;
  logic        gm_read;
  logic [31:0] gm_readdata;
  logic        gm_write;
  logic [31:0] gm_writedata;

  pawn_sweep #(.PAWN_CODE(PAWN)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .slave_waitrequest (slave_waitrequest),
    .slave_address     (slave_address),
    .slave_read        (slave_read),
    .slave_readdata    (slave_readdata),
    .slave_write       (slave_write),
    .slave_writedata   (slave_writedata),
    .bm_waitrequest    (bm_waitrequest),
    .bm_address        (bm_address),
    .bm_read           (bm_read),
    .bm_readdata       (bm_readdata),
    .bm_readdatavalid  (bm_readdatavalid),
    .gm_waitrequest    (gm_waitrequest),
    .gm_address        (gm_address),
    .gm_read           (gm_read),
    .gm_readdata       (gm_readdata),
    .gm_write          (gm_write),
    .gm_writedata      (gm_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- bus models ----------------
  logic [7:0]  board [64];
  logic [31:0] plan[$];
  logic [31:0] cnt_q[$];
  logic [31:0] bm_log[$];
  logic [63:0] gm_log[$];
  int          bm_wp = 0, gm_wp = 0, lat_max = 1, bm_hold = 0, gm_hold = 0;
  int          rd_cnt = 0;
  logic [7:0]  rd_byte;
  bit          pop_pending = 0;
  logic [31:0] src_m = 0;
  bit          prev_bm = 0, prev_gm = 0;
  logic [31:0] prev_bm_addr, prev_gm_data, off, rnd;
  logic [3:0]  prev_gm_addr;
  logic [1:0]  prev_gm_str, n_strobe;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0; pop_pending = 0; prev_bm = 0; prev_gm = 0;
      bm_readdatavalid = 0; bm_waitrequest = 0; gm_waitrequest = 0;
    end else begin
      n_strobe = 2'(bm_read) + 2'(gm_read) + 2'(gm_write);
      check_value("strobe_excl", {31'd0, n_strobe <= 2'd1}, 32'd1);
      if (!bm_read) check_value("bm_addr_idle", bm_address, 32'd0);
      if (!gm_read && !gm_write) begin
        check_value("gm_addr_idle", {28'd0, gm_address}, 32'd0);
        check_value("gm_wdata_idle", gm_writedata, 32'd0);
      end
      if (prev_bm) begin
        check_value("bm_stall_read", {31'd0, bm_read}, 32'd1);
        check_value("bm_stall_addr", bm_address, prev_bm_addr);
      end
      if (prev_gm) begin
        check_value("gm_stall_strobe", {30'd0, gm_read, gm_write}, {30'd0, prev_gm_str});
        check_value("gm_stall_addr", {28'd0, gm_address}, {28'd0, prev_gm_addr});
        check_value("gm_stall_data", gm_writedata, prev_gm_data);
      end
      // SDRAM read return path
      bm_readdatavalid = 0;
      rnd = $urandom;
      bm_readdata = rnd;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bm_readdatavalid = 1;
          bm_readdata = {rnd[31:8], rd_byte};
        end
      end
      if (bm_read && bm_hold > 0) begin
        bm_waitrequest = 1; bm_hold--;
      end else begin
        bm_waitrequest = ($urandom_range(0, 99) < bm_wp);
      end
      if (bm_read && !bm_waitrequest) begin
        bm_log.push_back(bm_address);
        off = bm_address - src_m;
        check_value("bm_in_range", {31'd0, (off < 32'd256) && (off[1:0] == 2'b00)}, 32'd1);
        rd_byte = board[off[7:2]];
        rd_cnt  = $urandom_range(1, lat_max);
      end
      prev_bm = bm_read && bm_waitrequest;
      prev_bm_addr = bm_address;
      // generator
      if (pop_pending) begin
        if (cnt_q.size() > 0) void'(cnt_q.pop_front());
        pop_pending = 0;
      end
      if (gm_read && gm_hold > 0) begin
        gm_waitrequest = 1; gm_hold--;
      end else begin
        gm_waitrequest = ($urandom_range(0, 99) < gm_wp);
      end
      // Poison the data while stalled so an early latch shows up in the total.
      gm_readdata = gm_waitrequest ? 32'hBAD0_0BAD : ((cnt_q.size() > 0) ? cnt_q[0] : 32'd0);
      if (gm_write && !gm_waitrequest) gm_log.push_back({28'd0, gm_address, gm_writedata});
      if (gm_read && !gm_waitrequest) pop_pending = 1;
      prev_gm = (gm_read || gm_write) && gm_waitrequest;
      prev_gm_str = {gm_read, gm_write};
      prev_gm_addr = gm_address;
      prev_gm_data = gm_writedata;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic slv_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_write = 1; slave_address = a; slave_writedata = d;
    @(negedge clk);
    slave_write = 0; slave_address = 4'd0; slave_writedata = 32'd0;
  endtask

  task automatic slv_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    #1 d = slave_readdata;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 8'd0;
    plan.delete();
  endtask

  task automatic gen_board(input bit sd);
    logic [7:0] tgt;
    tgt = sd ? 8'(-PAWN) : 8'(PAWN);
    plan.delete();
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 7))
        0: board[i] = 8'(PAWN);
        1: board[i] = 8'(-PAWN);
        2: board[i] = 8'($urandom);
        default: board[i] = 8'd0;
      endcase
      if (board[i] == tgt)
        plan.push_back(($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 50)));
    end
  endtask

  task automatic run_sweep(input logic [31:0] src, input logic [31:0] base, input bit sd,
                           input bit timed, input bit poke);
    logic [7:0]  tgt;
    logic [63:0] exp_gm[$];
    logic [31:0] exp_total, ptr, c, d;
    int          k, cyc;
    // reference: walk the squares in order, one generator call per own pawn
    tgt = sd ? 8'(-PAWN) : 8'(PAWN);
    exp_total = 0; ptr = base; k = 0;
    for (int s = 0; s < 64; s++) begin
      if (board[s] == tgt) begin
        exp_gm.push_back({32'd1, src});
        exp_gm.push_back({32'd2, ptr});
        exp_gm.push_back({32'd3, 32'(s % 8)});
        exp_gm.push_back({32'd4, 32'(s / 8)});
        exp_gm.push_back({32'd0, 32'd0});
        c = (k < plan.size()) ? plan[k] : 32'd0;
        k++;
        exp_total = exp_total + c;
        ptr = ptr + c * 32'd256;
      end
    end
    slv_write(4'd1, src);
    slv_write(4'd2, base);
    slv_write(4'd3, {31'd0, sd});
    src_m = src;
    bm_log.delete(); gm_log.delete();
    cnt_q = plan;
    slv_write(4'd0, 32'd0);
    if (poke) begin
      repeat (10) @(negedge clk);
      slv_write(4'd0, 32'd0);
      slv_write(4'd1, 32'h0000_1234);
    end
    #1;
    cyc = 0;
    while (slave_readdata[0] && cyc < 20000) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check_value("sweep_done", {31'd0, slave_readdata[0]}, 32'd0);
    if (timed) check_value("sweep_cycles", 32'(cyc), 32'd256);
    check_value("bm_reads", 32'(bm_log.size()), 32'd64);
    for (int i = 0; i < 64 && i < bm_log.size(); i++)
      check_value("bm_addr", bm_log[i], src + 32'(4 * i));
    check_value("gm_writes", 32'(gm_log.size()), 32'(exp_gm.size()));
    for (int i = 0; i < exp_gm.size() && i < gm_log.size(); i++) begin
      check_value("gm_addr", gm_log[i][63:32], exp_gm[i][63:32]);
      check_value("gm_data", gm_log[i][31:0], exp_gm[i][31:0]);
    end
    slv_read(4'd4, d);
    check_value("total_moves", d, exp_total);
    slv_read(4'd7, d);
    check_value("rd_unmapped", d, 32'd0);
    slave_address = 4'd0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d;
    int          cyc, log_n;
    rst_n = 0; slave_address = 0; slave_read = 0; slave_write = 0; slave_writedata = 0;
    bm_waitrequest = 0; bm_readdata = 0; bm_readdatavalid = 0;
    gm_waitrequest = 0; gm_readdata = 0;
    repeat (3) @(negedge clk);
    slv_read(4'd0, d);
    check_value("rst_busy", d, 32'd0);
    slv_read(4'd4, d);
    check_value("rst_total", d, 32'd0);
    check_value("rst_strobes", {29'd0, bm_read, gm_read, gm_write}, 32'd0);
    check_value("slave_wait", {31'd0, slave_waitrequest}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // empty board: 4 cycles per square
    clear_board();
    run_sweep(32'h0000_1000, 32'h0000_8000, 1'b0, 1'b1, 1'b0);

    // single white pawn on square 8
    clear_board();
    board[8] = 8'(PAWN);
    plan.push_back(32'd2);
    run_sweep(32'h0001_0000, 32'h0004_0000, 1'b0, 1'b0, 1'b0);

    // black side with stalls on the first board read and first poll
    clear_board();
    board[48] = 8'(-PAWN); board[55] = 8'(-PAWN);
    board[10] = 8'(PAWN);  board[60] = 8'(PAWN);
    plan.push_back(32'd3); plan.push_back(32'd1);
    bm_hold = 5; gm_hold = 7;
    run_sweep(32'h0002_0000, 32'h0010_0000, 1'b1, 1'b0, 1'b0);
    check_value("bm_hold_used", 32'(bm_hold), 32'd0);
    check_value("gm_hold_used", 32'(gm_hold), 32'd0);
    if (gm_log.size() > 6) check_value("black_dst2", gm_log[6][31:0], 32'h0010_0300);

    // writes while busy are ignored
    gen_board(1'b0);
    bm_wp = 20; gm_wp = 20; lat_max = 2;
    run_sweep(32'h0003_0000, 32'h0020_0000, 1'b0, 1'b0, 1'b1);

    // asynchronous reset while in G_Y
    bm_wp = 0; gm_wp = 0; lat_max = 1;
    clear_board();
    board[0] = 8'(PAWN);
    plan.push_back(32'd5);
    slv_write(4'd1, 32'h0000_4000);
    slv_write(4'd2, 32'h0009_0000);
    slv_write(4'd3, 32'd0);
    src_m = 32'h0000_4000;
    bm_log.delete(); gm_log.delete();
    cnt_q = plan;
    slv_write(4'd0, 32'd0);
    cyc = 0;
    #1;
    while (!(gm_write && gm_address == 4'd4) && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check_value("reached_g_y", {31'd0, gm_write && gm_address == 4'd4}, 32'd1);
    #2 rst_n = 0;
    #1 check_value("rst_async_strobes", {29'd0, bm_read, gm_read, gm_write}, 32'd0);
    log_n = gm_log.size();
    slv_read(4'd0, d);
    check_value("rst_mid_busy", d, 32'd0);
    slv_read(4'd4, d);
    check_value("rst_mid_total", d, 32'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    check_value("rst_no_gm", 32'(gm_log.size()), 32'(log_n));
    slv_read(4'd0, d);
    check_value("rst_idle", d, 32'd0);

    // randomized sweeps after reset
    for (int t = 0; t < 5; t++) begin
      bit sd;
      sd = 1'($urandom_range(0, 1));
      gen_board(sd);
      bm_wp = 30; gm_wp = 30; lat_max = 3;
      run_sweep($urandom & 32'hFFFF_FFFC, $urandom, sd, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
